// File: rtl/fft_pkg.sv
// Shared defaults and state encoding for the FFT frame capture slice.
// Optional peak tracking is enabled with FFT_CAPTURE_PEAK_EN.
package fft_pkg;

    localparam int NFFT  = 1024;
    localparam int LOG2N = 10;
    localparam int DW    = 32;

    localparam logic ST_CAPTURE = 1'b0;
    localparam logic ST_DONE    = 1'b1;

    typedef enum logic {
        CAPTURE = ST_CAPTURE,
        DONE    = ST_DONE
    } state_t;

endpackage

// File: rtl/fft_frame_capture_if.sv
// Stream-in, read-out and status bundle of fft_frame_capture.
// The slave modport is the capture block, the master is its environment.
interface fft_frame_capture_if
    import fft_pkg::*;
#(
    parameter int DW    = fft_pkg::DW,
    parameter int LOG2N = fft_pkg::LOG2N
);
    logic signed [DW-1:0] s_axis_data_tdata_re;
    logic signed [DW-1:0] s_axis_data_tdata_im;
    logic                 s_axis_data_tvalid;
    logic                 s_axis_data_tlast;
    logic                 s_axis_data_tready;
    logic                 frame_ack;
    logic                 rd_en;
    logic [LOG2N-1:0]     rd_addr;
    logic [DW-1:0]        rd_data_re;
    logic [DW-1:0]        rd_data_im;
    logic                 rd_valid;
    logic                 frame_done;
    logic [LOG2N-1:0]     peak_bin;
    logic [DW:0]          peak_mag;
    logic                 tlast_err;

    modport master (
        output s_axis_data_tdata_re,
        output s_axis_data_tdata_im,
        output s_axis_data_tvalid,
        output s_axis_data_tlast,
        output frame_ack,
        output rd_en,
        output rd_addr,
        input  s_axis_data_tready,
        input  rd_data_re,
        input  rd_data_im,
        input  rd_valid,
        input  frame_done,
        input  peak_bin,
        input  peak_mag,
        input  tlast_err
    );

    modport slave (
        input  s_axis_data_tdata_re,
        input  s_axis_data_tdata_im,
        input  s_axis_data_tvalid,
        input  s_axis_data_tlast,
        input  frame_ack,
        input  rd_en,
        input  rd_addr,
        output s_axis_data_tready,
        output rd_data_re,
        output rd_data_im,
        output rd_valid,
        output frame_done,
        output peak_bin,
        output peak_mag,
        output tlast_err
    );

endinterface

// File: rtl/fft_capture_ram.sv
// Simple dual-port frame RAM: sync write, registered 1-cycle read.
// No reset on the array or read register so it maps onto block RAM.
module fft_capture_ram
    import fft_pkg::*;
#(
    parameter int AW = fft_pkg::LOG2N,
    parameter int W  = 2 * fft_pkg::DW
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [2**AW];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_frame_capture.sv
// Captures one NFFT-point complex frame, tracks its peak bin, then serves reads.
// Peak/magnitude logic only exists when FFT_CAPTURE_PEAK_EN is defined.
module fft_frame_capture
    import fft_pkg::*;
#(
    parameter int NFFT  = fft_pkg::NFFT,
    parameter int LOG2N = fft_pkg::LOG2N,
    parameter int DW    = fft_pkg::DW
) (
    input  logic              clk,
    input  logic              rst,
    fft_frame_capture_if.slave bus
);

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(NFFT - 1);

    state_t           r_state;
    logic [LOG2N-1:0] r_wr_idx;
    logic             r_tready;
    logic             r_done;
    logic             r_rd_valid;
    logic             r_rd_hold;
    logic             r_tlast_err;

    logic             w_accept;
    logic             w_last;
    logic             w_rd_go;
    logic             w_ack;
    logic [2*DW-1:0]  w_wdata;
    logic [2*DW-1:0]  w_rdata;

    assign w_accept = bus.s_axis_data_tvalid && r_tready;
    assign w_last   = (r_wr_idx == LAST_IDX);
    assign w_rd_go  = bus.rd_en && (r_state == DONE);
    assign w_ack    = bus.frame_ack && (r_state == DONE);
    assign w_wdata  = {bus.s_axis_data_tdata_re, bus.s_axis_data_tdata_im};

    fft_capture_ram #(
        .AW (LOG2N),
        .W  (2 * DW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (r_wr_idx),
        .i_wdata (w_wdata),
        .i_re    (w_rd_go),
        .i_raddr (bus.rd_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= CAPTURE;
            r_wr_idx    <= '0;
            r_tready    <= 1'b1;
            r_done      <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_hold   <= 1'b0;
            r_tlast_err <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_go;
            if (w_rd_go) begin
                r_rd_hold <= 1'b1;
            end
            unique case (r_state)
                CAPTURE: begin
                    if (w_accept) begin
                        r_wr_idx <= r_wr_idx + 1'b1;
                        // tlast only audits framing; length is fixed at NFFT
                        if (bus.s_axis_data_tlast != w_last) begin
                            r_tlast_err <= 1'b1;
                        end
                        if (w_last) begin
                            r_state  <= DONE;
                            r_tready <= 1'b0;
                            r_done   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.frame_ack) begin
                        r_state     <= CAPTURE;
                        r_tready    <= 1'b1;
                        r_done      <= 1'b0;
                        r_tlast_err <= 1'b0;
                    end
                end
                default: r_state <= CAPTURE;
            endcase
        end
    end

`ifdef FFT_CAPTURE_PEAK_EN
    localparam logic [DW:0] ONE = (DW+1)'(1);

    logic [DW:0]      w_abs_re;
    logic [DW:0]      w_abs_im;
    logic [DW:0]      w_mag;
    logic [LOG2N-1:0] r_peak_bin;
    logic [DW:0]      r_peak_mag;

    // DW+1 bits hold |-2^(DW-1)| and the L1 sum without saturation
    assign w_abs_re = bus.s_axis_data_tdata_re[DW-1]
                    ? ({1'b0, ~bus.s_axis_data_tdata_re} + ONE)
                    : {1'b0, bus.s_axis_data_tdata_re};
    assign w_abs_im = bus.s_axis_data_tdata_im[DW-1]
                    ? ({1'b0, ~bus.s_axis_data_tdata_im} + ONE)
                    : {1'b0, bus.s_axis_data_tdata_im};
    assign w_mag    = w_abs_re + w_abs_im;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_peak_bin <= '0;
            r_peak_mag <= '0;
        end else if (w_ack) begin
            r_peak_bin <= '0;
            r_peak_mag <= '0;
        end else if (w_accept) begin
            if ((r_wr_idx == '0) || (w_mag > r_peak_mag)) begin
                r_peak_bin <= r_wr_idx;
                r_peak_mag <= w_mag;
            end
        end
    end

    assign bus.peak_bin = r_peak_bin;
    assign bus.peak_mag = r_peak_mag;
`else
    assign bus.peak_bin = '0;
    assign bus.peak_mag = '0;
`endif

    // RAM read register has no reset; mask it until a read has been served
    assign bus.rd_data_re = r_rd_hold ? w_rdata[2*DW-1:DW] : '0;
    assign bus.rd_data_im = r_rd_hold ? w_rdata[DW-1:0]    : '0;

    assign bus.s_axis_data_tready = r_tready;
    assign bus.rd_valid           = r_rd_valid;
    assign bus.frame_done         = r_done;
    assign bus.tlast_err          = r_tlast_err;

endmodule

// File: tb/tb_fft_frame_capture.sv
// Scoreboard bench for fft_frame_capture: reads and frame results are queued
// at stimulus time and popped by a monitor when rd_valid / frame_done appear.
module tb_fft_frame_capture;
    import fft_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] re;
        logic [31:0] im;
    } rd_exp_t;

    typedef struct {
        string       name;
        logic [9:0]  bin;
        logic [32:0] mag;
        logic        err;
    } fr_exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fft_frame_capture_if #(.DW(32), .LOG2N(10)) bus ();

    fft_frame_capture dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    rd_exp_t rq[$];
    fr_exp_t fq[$];
    int      errors = 0;
    int      checks = 0;
    logic    prev_done = 1'b0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic fr_exp_t fexp(string n, int bin, logic [32:0] mag,
                                     logic err);
        fr_exp_t e;
        e.name = n;
`ifdef FFT_CAPTURE_PEAK_EN
        e.bin = 10'(bin);
        e.mag = mag;
`else
        e.bin = '0;
        e.mag = '0;
`endif
        e.err = err;
        return e;
    endfunction

    // monitor: pops expectations when the DUT presents results
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_done = 1'b0;
            end else begin
                if (bus.rd_valid === 1'b1) begin
                    if (rq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rd_valid_unexpected: got 1 expected 0");
                    end else begin
                        rd_exp_t e;
                        e = rq.pop_front();
                        chk({e.name, "_re"}, bus.rd_data_re, e.re);
                        chk({e.name, "_im"}, bus.rd_data_im, e.im);
                    end
                end
                if (bus.frame_done === 1'b1 && !prev_done) begin
                    if (fq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_done_unexpected: got 1 expected 0");
                    end else begin
                        fr_exp_t f;
                        f = fq.pop_front();
                        chk({f.name, "_peak_bin"}, bus.peak_bin, f.bin);
                        chk({f.name, "_peak_mag"}, bus.peak_mag, f.mag);
                        chk({f.name, "_tlast_err"}, bus.tlast_err, f.err);
                    end
                end
                prev_done = bus.frame_done;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic void beat_vals(int kind, int i,
                                      output logic [31:0] re,
                                      output logic [31:0] im,
                                      output logic last);
        re   = '0;
        im   = '0;
        last = (i == 1023);
        case (kind)
            0: re = 32'(i);
            1: begin
                if (i == 100) begin
                    re = 32'(-50);
                    im = 32'(25);
                end
                if (i == 900) re = 32'(75);
                last = (i == 500);
            end
            2: if (i == 7) begin
                re = 32'h8000_0000;
                im = 32'h8000_0000;
            end
            3: begin
                re   = (i == 10) ? 32'(5000) : 32'(i);
                last = 1'b0;
            end
            default: begin
                re = 32'(i % 5);
                if (i == 600) begin
                    re = 32'(-9);
                    im = 32'(4);
                end
                if (i == 601) begin
                    re = '0;
                    im = 32'(-13);
                end
            end
        endcase
    endfunction

    task automatic send_beat(logic [31:0] re, logic [31:0] im,
                             logic last, int gap);
        int n;
        bus.s_axis_data_tvalid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.s_axis_data_tdata_re = re;
        bus.s_axis_data_tdata_im = im;
        bus.s_axis_data_tlast    = last;
        bus.s_axis_data_tvalid   = 1'b1;
        n = 0;
        while (bus.s_axis_data_tready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL tready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        bus.s_axis_data_tvalid = 1'b0;
        bus.s_axis_data_tlast  = 1'b0;
    endtask

    task automatic send_frame(int kind, int n, bit gaps);
        logic [31:0] re;
        logic [31:0] im;
        logic        last;
        for (int i = 0; i < n; i++) begin
            beat_vals(kind, i, re, im, last);
            if (i == 1023) chk("done_early", bus.frame_done, 1'b0);
            send_beat(re, im, last, gaps ? int'($urandom_range(0, 1)) : 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(string n, int addr, logic [31:0] re,
                           logic [31:0] im);
        rd_exp_t e;
        e.name = n;
        e.re   = re;
        e.im   = im;
        rq.push_back(e);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 10'(addr);
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic ack();
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
    endtask

    initial begin
        rst                      = 1'b1;
        bus.s_axis_data_tdata_re = '0;
        bus.s_axis_data_tdata_im = '0;
        bus.s_axis_data_tvalid   = 1'b0;
        bus.s_axis_data_tlast    = 1'b0;
        bus.frame_ack            = 1'b0;
        bus.rd_en                = 1'b0;
        bus.rd_addr              = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tready", bus.s_axis_data_tready, 1'b1);
        chk("rst_frame_done", bus.frame_done, 1'b0);
        chk("rst_rd_valid", bus.rd_valid, 1'b0);
        chk("rst_rd_re", bus.rd_data_re, 32'h0);
        chk("rst_rd_im", bus.rd_data_im, 32'h0);
        chk("rst_peak_bin", bus.peak_bin, 10'h0);
        chk("rst_peak_mag", bus.peak_mag, 33'h0);
        chk("rst_tlast_err", bus.tlast_err, 1'b0);
        tick();

        // frame A: ramp, peak at last bin
        fq.push_back(fexp("A", 1023, 33'd1023, 1'b0));
        send_frame(0, 1024, 1'b0);
        @(negedge clk);
        chk("A_done", bus.frame_done, 1'b1);
        chk("A_tready", bus.s_axis_data_tready, 1'b0);
        tick();
        do_read("A_rd5", 5, 32'd5, 32'd0);
        do_read("A_rd0", 0, 32'd0, 32'd0);
        do_read("A_rd1023", 1023, 32'd1023, 32'd0);
        repeat (2) tick();
        ack();
        @(negedge clk);
        chk("A_ack_tready", bus.s_axis_data_tready, 1'b1);
        chk("A_ack_done", bus.frame_done, 1'b0);
        tick();
        // read while capturing is ignored, data holds
        bus.rd_en   = 1'b1;
        bus.rd_addr = 10'd5;
        tick();
        bus.rd_en = 1'b0;
        @(negedge clk);
        chk("cap_rd_valid", bus.rd_valid, 1'b0);
        chk("cap_rd_hold", bus.rd_data_re, 32'd1023);
        tick();

        // frame B: gaps, misplaced tlast, tied peak keeps lower bin
        fq.push_back(fexp("B", 100, 33'd75, 1'b1));
        send_frame(1, 1024, 1'b1);
        @(negedge clk);
        chk("B_done", bus.frame_done, 1'b1);
        chk("B_tlast_err", bus.tlast_err, 1'b1);
        tick();
        bus.s_axis_data_tdata_re = 32'hDEAD_BEEF;
        bus.s_axis_data_tvalid   = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("B_stall_tready", bus.s_axis_data_tready, 1'b0);
        chk("B_stall_done", bus.frame_done, 1'b1);
        tick();
        bus.s_axis_data_tvalid = 1'b0;
        do_read("B_rd900", 900, 32'd75, 32'd0);
        do_read("B_rd100", 100, 32'hFFFF_FFCE, 32'd25);
        do_read("B_rd0", 0, 32'd0, 32'd0);
        tick();
        // read and ack on the same cycle
        begin
            rd_exp_t e;
            e.name = "B_rd_ack";
            e.re   = 32'd75;
            e.im   = 32'd0;
            rq.push_back(e);
        end
        bus.rd_en     = 1'b1;
        bus.rd_addr   = 10'd900;
        bus.frame_ack = 1'b1;
        tick();
        bus.rd_en     = 1'b0;
        bus.frame_ack = 1'b0;
        @(negedge clk);
        chk("B_ack_tready", bus.s_axis_data_tready, 1'b1);
        chk("B_ack_err", bus.tlast_err, 1'b0);
        chk("B_ack_done", bus.frame_done, 1'b0);
        chk("B_ack_peak", bus.peak_mag, 33'h0);
        tick();

        // frame C: most negative components at bin 7
        fq.push_back(fexp("C", 7, 33'h1_0000_0000, 1'b0));
        send_frame(2, 1024, 1'b0);
        tick();
        do_read("C_rd7", 7, 32'h8000_0000, 32'h8000_0000);
        tick();
        ack();
        tick();

        // partial frame D discarded by reset
        send_frame(3, 300, 1'b0);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("D_rst_tready", bus.s_axis_data_tready, 1'b1);
        chk("D_rst_done", bus.frame_done, 1'b0);
        tick();

        // frame E: fresh frame after reset, tie between bins 600/601
        fq.push_back(fexp("E", 600, 33'd13, 1'b0));
        send_frame(4, 1024, 1'b0);
        @(negedge clk);
        chk("E_done", bus.frame_done, 1'b1);
        tick();
        do_read("E_rd600", 600, 32'hFFFF_FFF7, 32'd4);
        do_read("E_rd601", 601, 32'd0, 32'hFFFF_FFF3);
        do_read("E_rd10", 10, 32'd0, 32'd0);
        repeat (3) tick();
        ack();
        repeat (3) tick();

        chk("rd_queue_empty", 64'(rq.size()), 64'd0);
        chk("frame_queue_empty", 64'(fq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
